// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two NIBBLES*4-bit operands plus a carry-in by
// streaming one nibble pair per clock (LSB first) through a single 4-bit
// ripple-carry adder. The carry between nibbles lives only in carry_r, so the
// widest combinational path is one 4-bit adder.

module full_adder_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   // Four-bit ripple-carry add, bit 0 first
   always_comb begin
      logic c_v;
      s   = 4'd0;
      c_v = ci;
      for (int i = 0; i < 4; i++) begin
         s[i] = a[i] ^ b[i] ^ c_v;
         c_v  = (a[i] & b[i]) | (c_v & (a[i] ^ b[i]));
      end
      co = c_v;
   end

endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout
);

   localparam int W     = 4 * NIBBLES;
   localparam int CNT_W = $clog2(NIBBLES) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             next_s;
   logic [W-1:0]       a_r;
   logic [W-1:0]       b_r;
   logic [W-1:0]       sum_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               carry_r;
   logic               cout_r;
   logic               busy_r;
   logic               done_r;
   logic               last_s;
   logic [3:0]         nib_a_s;
   logic [3:0]         nib_b_s;
   logic [3:0]         nib_s_s;
   logic               nib_co_s;
   logic [CNT_W+1:0]   bit_base_s;

   // The nibble currently selected by cnt_r is at bit offset 4*cnt_r
   assign bit_base_s = {cnt_r, 2'b00};
   assign nib_a_s    = 4'(a_r >> bit_base_s);
   assign nib_b_s    = 4'(b_r >> bit_base_s);
   assign last_s     = (cnt_r == CNT_W'(NIBBLES - 1));

   full_adder_4 u_fa (
      .a  (nib_a_s),
      .b  (nib_b_s),
      .ci (carry_r),
      .s  (nib_s_s),
      .co (nib_co_s)
   );

   // Next-state decode: IDLE waits for start, RUN walks the nibbles, DONE lasts one cycle
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_s = RUN;
            end else begin
               next_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               next_s = DONE;
            end else begin
               next_s = RUN;
            end
         end
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // State register and registered status flags derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         busy_r  <= (next_s != IDLE);
         done_r  <= (next_s == DONE);
      end
   end

   // Operand capture on accept, then one nibble of sum and the carry per RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         cnt_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= cin;
                  cnt_r   <= '0;
                  sum_r   <= '0;
                  cout_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            RUN: begin
               sum_r[bit_base_s +: 4] <= nib_s_s;
               carry_r                <= nib_co_s;
               cnt_r                  <= cnt_r + CNT_W'(1);
               if (last_s) begin
                  cout_r <= nib_co_s;
               end else begin
                  cout_r <= cout_r;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign sum  = sum_r;
   assign cout = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4 (16-bit operands).

module tb_nibble_serial_adder;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;

   int checks = 0;
   int errors = 0;

   nibble_serial_adder #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete add: accept, four RUN edges, DONE, back to IDLE.
   // With poke set, a start pulse carrying a=0xFFFF is driven mid-RUN.
   task automatic do_add(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] exp_sum, input logic exp_cout,
                         input bit poke);
      a = ta; b = tb; cin = tc; start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_accept"}, 32'(busy), 32'd1);
      check({tag, "_sum_cleared"}, 32'(sum), 32'd0);
      check({tag, "_cout_cleared"}, 32'(cout), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (poke && k == 1) begin
            start = 1'b1; a = 16'hFFFF;
         end
         if (poke && k == 2) begin
            start = 1'b0;
         end
         check($sformatf("%s_done_k%0d", tag, k), 32'(done), (k == 4) ? 32'd1 : 32'd0);
      end
      check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
      tick();
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_busy_drop"}, 32'(busy), 32'd0);
      check({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
      #20;
      rst_n = 1'b1;
      tick();

      // 1..4: basic adds, ripple across nibbles, all-ones, ignored mid-RUN start
      do_add("t1_zero",   16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      do_add("t2_ripple", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      do_add("t3_ones",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      do_add("t4_poke",   16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b1);

      // 5: asynchronous reset at cnt=2 aborts, then a clean rerun
      a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("t5_abort_busy", 32'(busy), 32'd0);
      check("t5_abort_done", 32'(done), 32'd0);
      check("t5_abort_sum", 32'(sum), 32'd0);
      check("t5_abort_cout", 32'(cout), 32'd0);
      #10;
      rst_n = 1'b1;
      tick();
      check("t5_idle_after_reset", 32'(busy), 32'd0);
      do_add("t5_rerun", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0);

      // 6: start held high gives back-to-back adds, done every 6 cycles
      a = 16'h000F; b = 16'h0001; cin = 1'b0; start = 1'b1;
      tick();
      check("t6_accept0", 32'(busy), 32'd1);
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (k == 18) begin
            start = 1'b0;
         end
         check($sformatf("t6_done_k%0d", k), 32'(done), (k % 6 == 4) ? 32'd1 : 32'd0);
         check($sformatf("t6_busy_k%0d", k), 32'(busy), (k % 6 == 5) ? 32'd0 : 32'd1);
         if (k % 6 == 4) begin
            check($sformatf("t6_sum_k%0d", k), 32'(sum), 32'h0010);
            check($sformatf("t6_cout_k%0d", k), 32'(cout), 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
